div_arbiter: RTL and testbench

- Round-robin scheduler sharing one 24/8 restoring divider (16-bit quotient) among NREQ requesters.
- Latches the winning requester's operands and clears the divider. It then pulses start, waits for the divider's done pulse and returns the quotient with a per-requester done strobe.
- Divide-by-zero and quotient-overflow requests are screened out and answered directly, without invoking the divider.

---
 rtl/div_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one 24/8 restoring divider among NREQ requesters.
// Optional WAIT-state timeout is compiled in with `define DIV_TIMEOUT_EN.
module div_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   dividend,
  input  logic [8*NREQ-1:0]    divisor,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          quotient,
  output logic                 dz_err,
  output logic                 ovf_err,
  output logic                 busy,
  output logic [23:0]          div_big,
  output logic [7:0]           div_smal,
  output logic                 div_clr,
  output logic                 div_start,
  input  logic [15:0]          div_q,
  input  logic                 div_done
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("div_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
    $error("div_arbiter: TIMEOUT must be in 1..256");
  end

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_gidx;
  logic [NREQ-1:0] r_gnt;
  logic [15:0]     r_quot;
  logic            r_dz, r_ovf;
  logic [23:0]     r_big;
  logic [7:0]      r_smal;

  logic            w_found;
  logic [PW-1:0]   w_sel, w_idx;
  logic [NREQ-1:0] w_onehot;
  logic [23:0]     w_sel_big;
  logic [7:0]      w_sel_smal;
  logic            w_dz, w_ovf, w_to;

  // Rotating priority scan: the first set request at or after the pointer wins.
  always_comb begin
    w_found  = 1'b0;
    w_sel    = '0;
    w_idx    = '0;
    w_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_onehot[w_sel] = 1'b1;
  end

  assign w_sel_big  = dividend[32'(w_sel)*24 +: 24];
  assign w_sel_smal = divisor[32'(w_sel)*8 +: 8];
  assign w_dz       = (w_sel_smal == '0);
  // Quotient fits in 16 bits only when the top dividend byte is below the divisor.
  assign w_ovf      = (w_sel_big[23:16] >= w_sel_smal);

`ifdef DIV_TIMEOUT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == START) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_to = (r_state == WAIT) && !div_done && (r_cnt == 8'(TIMEOUT - 1));
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    done      = '0;
    div_clr   = 1'b0;
    div_start = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_found) w_next = (w_dz || w_ovf) ? RESP : CLR;
      end
      CLR: begin
        div_clr = 1'b1;
        w_next  = START;
      end
      START: begin
        div_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        div_clr = w_to;
        if (div_done || w_to) w_next = RESP;
      end
      RESP: begin
        done   = r_gnt;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= '0;
      r_gidx <= '0;
      r_gnt  <= '0;
      r_quot <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
      r_big  <= '0;
      r_smal <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gidx <= w_sel;
            r_gnt  <= w_onehot;
            r_big  <= w_sel_big;
            r_smal <= w_sel_smal;
            if (w_dz) begin
              r_quot <= 16'hFFFF;
              r_dz   <= 1'b1;
              r_ovf  <= 1'b0;
            end else if (w_ovf) begin
              r_quot <= 16'hFFFF;
              r_dz   <= 1'b0;
              r_ovf  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (div_done) begin
            r_quot <= div_q;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
          end else if (w_to) begin
            r_quot <= '0;
            r_dz   <= 1'b1;
            r_ovf  <= 1'b1;
          end
        end
        RESP: begin
          r_gnt <= '0;
          r_ptr <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign quotient = r_quot;
  assign dz_err   = r_dz;
  assign ovf_err  = r_ovf;
  assign div_big  = r_big;
  assign div_smal = r_smal;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table, hand sequences and a
// randomized round-robin phase against a behavioural divider/arbiter model.
module tb_div_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [24*NREQ-1:0] dividend;
  logic [8*NREQ-1:0] divisor;
  logic [NREQ-1:0]   gnt, done;
  logic [15:0]       quotient;
  logic              dz_err, ovf_err, busy;
  logic [23:0]       div_big;
  logic [7:0]        div_smal;
  logic              div_clr, div_start;
  logic [15:0]       div_q;
  logic              div_done;

  logic [23:0] opd [NREQ];
  logic [7:0]  opv [NREQ];
  assign dividend = {opd[3], opd[2], opd[1], opd[0]};
  assign divisor  = {opv[3], opv[2], opv[1], opv[0]};

  div_arbiter #(.NREQ(NREQ), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .req(req), .dividend(dividend), .divisor(divisor),
    .gnt(gnt), .done(done), .quotient(quotient), .dz_err(dz_err), .ovf_err(ovf_err),
    .busy(busy), .div_big(div_big), .div_smal(div_smal), .div_clr(div_clr),
    .div_start(div_start), .div_q(div_q), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned ncyc = 0;
  always @(posedge clk) ncyc++;

  // Behavioural divider: answers each start with floor(big/small) after 1..5 cycles.
  logic        dm_tie0 = 1'b0, dm_force = 1'b0, dm_busy = 1'b0;
  logic [15:0] dm_force_q = '0, dm_res = '0;
  int unsigned dm_cnt = 0, dm_ddone_cyc = 0, dm_start_cyc = 0;
  int unsigned n_start = 0, n_clr = 0;

  initial begin
    div_done = 1'b0;
    div_q    = '0;
  end

  always @(negedge clk) begin
    div_done = 1'b0;
    if (!reset) begin
      dm_busy = 1'b0;
    end else if (dm_force) begin
      div_done = 1'b1;
      div_q    = dm_force_q;
      dm_force = 1'b0;
    end else if (!dm_tie0) begin
      if (dm_busy) begin
        if (dm_cnt == 0) begin
          div_done     = 1'b1;
          div_q        = dm_res;
          dm_busy      = 1'b0;
          dm_ddone_cyc = ncyc;
        end else begin
          dm_cnt--;
        end
      end
      if (div_start) begin
        dm_busy = 1'b1;
        dm_cnt  = $urandom_range(0, 4);
        dm_res  = 16'(int'(div_big) / int'(div_smal));
      end
    end
    if (div_start) begin
      n_start++;
      dm_start_cyc = ncyc;
    end
    if (div_clr) n_clr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: overflow means the true quotient needs more than 16 bits.
  function automatic void ref_div(input logic [23:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic dz, output logic ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = 16'hFFFF;
      dz = 1'b1;
    end else if (int'(a) / int'(b) > 65535) begin
      q  = 16'hFFFF;
      ov = 1'b1;
    end else begin
      q = 16'(int'(a) / int'(b));
    end
  endfunction

  int          m_ptr = 0;
  int          served[$];
  int unsigned t_drive, t_done;
  logic [15:0] last_q;
  logic        last_dz, last_ov;

  // Raise every request in mask, then check each completion against the model.
  task automatic serve(input logic [3:0] mask);
    logic [3:0]  pend;
    int          g, got;
    int unsigned w;
    logic [15:0] eq;
    logic        edz, eov;
    pend = mask;
    served.delete();
    t_drive = ncyc;
    req = mask;
    while (pend != 0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (done == '0 && w < 300);
      if (done == '0) begin
        chk("done_within_bound", 32'(w), 32'(0));
        req = '0;
        return;
      end
      t_done = ncyc;
      got = -1;
      for (int k = 0; k < NREQ; k++) if (done[k]) got = k;
      served.push_back(got);
      ref_div(opd[g], opv[g], eq, edz, eov);
      last_q  = quotient;
      last_dz = dz_err;
      last_ov = ovf_err;
      chk("done_onehot", 32'(done), 32'(1) << g);
      chk("gnt_with_done", 32'(gnt), 32'(1) << g);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("dz_err", 32'(dz_err), 32'(edz));
      chk("ovf_err", 32'(ovf_err), 32'(eov));
      pend[g] = 1'b0;
      req[g]  = 1'b0;
      m_ptr   = (g + 1) % NREQ;
      @(negedge clk);
      chk("gnt_drop_after_resp", 32'(gnt), 32'(0));
      chk("done_single_cycle", 32'(done), 32'(0));
      chk("quotient_held", 32'(quotient), 32'(eq));
      chk("flags_held", {30'd0, dz_err, ovf_err}, {30'd0, edz, eov});
    end
  endtask

  typedef struct {
    int          idx;
    logic [23:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b_start, b_clr, w, sawdone;
    logic [15:0] q_after;
    logic        err_path;

    tbl[0] = '{0, 24'd1000,    8'd7,   16'd142,   1'b0, 1'b0};
    tbl[1] = '{3, 24'd12345,   8'd0,   16'hFFFF,  1'b1, 1'b0};
    tbl[2] = '{0, 24'h0A0000,  8'd5,   16'hFFFF,  1'b0, 1'b1};
    tbl[3] = '{1, 24'hFEFFFF,  8'hFF,  16'hFFFF,  1'b0, 1'b0};
    tbl[4] = '{2, 24'hFF0000,  8'hFF,  16'hFFFF,  1'b0, 1'b1};
    tbl[5] = '{1, 24'd0,       8'd1,   16'd0,     1'b0, 1'b0};
    tbl[6] = '{2, 24'h00FFFF,  8'd1,   16'hFFFF,  1'b0, 1'b0};
    tbl[7] = '{3, 24'h010000,  8'd1,   16'hFFFF,  1'b0, 1'b1};

    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin
      opd[i] = '0;
      opv[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_flags", {30'd0, dz_err, ovf_err}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_ops", {div_big, div_smal}, 0);
    chk("rst_div_ctl", {30'd0, div_clr, div_start}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single-requester vectors.
    for (int t = 0; t < 8; t++) begin
      opd[tbl[t].idx] = tbl[t].dvd;
      opv[tbl[t].idx] = tbl[t].dvs;
      err_path = tbl[t].dz | tbl[t].ov;
      b_start = n_start;
      b_clr   = n_clr;
      serve(4'(1) << tbl[t].idx);
      chk("vec_quotient", 32'(last_q), 32'(tbl[t].q));
      chk("vec_flags", {30'd0, last_dz, last_ov}, {30'd0, tbl[t].dz, tbl[t].ov});
      chk("vec_start_count", n_start - b_start, err_path ? 0 : 1);
      chk("vec_clr_count", n_clr - b_clr, err_path ? 0 : 1);
      if (err_path) chk("err_latency", t_done - t_drive, 1);
      else          chk("norm_latency", t_done - dm_ddone_cyc, 1);
    end

    // Simultaneous requests: 1 then 2 from pointer 0, then pointer sits at 3.
    opd[1] = 24'd300; opv[1] = 8'd3;
    opd[2] = 24'd255; opv[2] = 8'd5;
    serve(4'b0110);
    chk("pair_count", served.size(), 2);
    if (served.size() == 2) begin
      chk("pair_first", 32'(served[0]), 1);
      chk("pair_second", 32'(served[1]), 2);
    end
    opd[0] = 24'd10; opv[0] = 8'd2;
    opd[3] = 24'd99; opv[3] = 8'd9;
    serve(4'b1001);
    chk("wrap_count", served.size(), 2);
    if (served.size() == 2) begin
      chk("wrap_first", 32'(served[0]), 3);
      chk("wrap_second", 32'(served[1]), 0);
    end

    // Divider that never answers.
    opd[0] = 24'd1000; opv[0] = 8'd7;
    dm_tie0 = 1'b1;
    b_start = n_start;
    b_clr   = n_clr;
    req = 4'b0001;
`ifdef DIV_TIMEOUT_EN
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (done == '0 && w < 100);
    chk("to_done", 32'(done), 32'b0001);
    chk("to_latency", ncyc - dm_start_cyc, 33);
    chk("to_quotient", 32'(quotient), 0);
    chk("to_flags", {30'd0, dz_err, ovf_err}, 32'b11);
    chk("to_clr_count", n_clr - b_clr, 2);
    q_after = 16'h0000;
`else
    sawdone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 10) opd[0] = 24'd55;
      if (done != '0) sawdone = 1;
    end
    chk("wait_no_done", sawdone, 0);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_start_count", n_start - b_start, 1);
    chk("wait_ops_held", {div_big, div_smal}, {24'd1000, 8'd7});
    dm_force_q = 16'h1234;
    dm_force   = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (done == '0 && w < 10);
    chk("late_done", 32'(done), 32'b0001);
    chk("late_quotient", 32'(quotient), 32'h1234);
    chk("late_flags", {30'd0, dz_err, ovf_err}, 0);
    q_after = 16'h1234;
`endif
    req = '0;
    m_ptr = 1;
    @(negedge clk);

    // div_done while idle must be ignored.
    dm_force_q = 16'hBEEF;
    dm_force   = 1'b1;
    sawdone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0 || busy) sawdone = 1;
    end
    chk("idle_div_done_ignored", sawdone, 0);
    chk("idle_quotient_kept", 32'(quotient), 32'(q_after));

    // Reset while waiting on the divider.
    opd[1] = 24'd5000; opv[1] = 8'd9;
    b_clr   = n_clr;
    b_start = n_start;
    req = 4'b0010;
    w = 0;
    while (n_start == b_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_test_started", n_start - b_start, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_quotient", 32'(quotient), 0);
    chk("midrst_flags", {30'd0, dz_err, ovf_err}, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ops", {div_big, div_smal}, 0);
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 0);
    chk("midrst_ctl", {30'd0, div_clr, div_start}, 0);
    chk("midrst_clr_count", n_clr - b_clr, 1);
    dm_tie0 = 1'b0;
    m_ptr   = 0;
    opd[0] = 24'd77; opv[0] = 8'd7;
    serve(4'b0011);
    chk("postrst_count", served.size(), 2);
    if (served.size() == 2) chk("postrst_ptr_zero", 32'(served[0]), 0);

    // Randomized rounds against the model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        opv[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        if (opv[i] == 0 || $urandom_range(0, 4) == 0)
          opd[i] = 24'($urandom);
        else
          opd[i] = 24'($urandom_range(0, (int'(opv[i]) << 16) - 1));
      end
      serve(4'($urandom_range(1, 15)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
